// File: rtl/matrix_stream_controller.sv
// rtl/matrix_stream_controller.sv - byte-stream front/back end for the 5x5 int8 matrix multiplier
// Loads A then B over a valid/ready stream, runs one 5-row pass, returns 25 result bytes.
module matrix_stream_controller (
  input  logic         clock,
  input  logic         reset,
  input  logic [7:0]   in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [7:0]   out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [199:0] matrix_a,
  output logic [199:0] matrix_b,
  output logic         mult_start,
  input  logic [199:0] mult_result,
  input  logic         mult_done,
  output logic         frame_done,
  output logic         error
);

  typedef enum logic [2:0] {
    S_SYNC   = 3'd0,
    S_LOAD_A = 3'd1,
    S_LOAD_B = 3'd2,
    S_RUN    = 3'd3,
    S_CHECK  = 3'd4,
    S_SEND   = 3'd5
  } state_t;

  state_t         state_q, state_d;
  logic [4:0]     idx_q, idx_d;
  logic [2:0]     cnt_q, cnt_d;
  logic [199:0]   mat_a_q, mat_a_d;
  logic [199:0]   mat_b_q, mat_b_d;
  logic [199:0]   res_q, res_d;
  logic           frame_done_q, frame_done_d;
  logic           error_q, error_d;
  logic           last_idx;
  logic           sync_hit;
  logic [7:0]     send_byte;

  // A done seen after at least one start cycle means the multiplier row just wrapped to 0.
  assign sync_hit = (cnt_q != 3'd0) && mult_done;
  assign last_idx = (idx_q == 5'd24);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_SYNC;
      idx_q        <= 5'd0;
      cnt_q        <= 3'd0;
      mat_a_q      <= '0;
      mat_b_q      <= '0;
      res_q        <= '0;
      frame_done_q <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      mat_a_q      <= mat_a_d;
      mat_b_q      <= mat_b_d;
      res_q        <= res_d;
      frame_done_q <= frame_done_d;
      error_q      <= error_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    mat_a_d      = mat_a_q;
    mat_b_d      = mat_b_q;
    res_d        = res_q;
    frame_done_d = 1'b0;
    error_d      = error_q;
    case (state_q)
      S_SYNC: begin
        if (sync_hit) begin
          state_d = S_LOAD_A;
          idx_d   = 5'd0;
          cnt_d   = 3'd0;
        end else if (cnt_q != 3'd7) begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      S_LOAD_A, S_LOAD_B: begin
        if (in_valid) begin
          for (int k = 0; k < 25; k++) begin
            if (idx_q == 5'(k)) begin
              if (state_q == S_LOAD_A) mat_a_d[8*k +: 8] = in_data;
              else                     mat_b_d[8*k +: 8] = in_data;
            end
          end
          if (last_idx) begin
            idx_d   = 5'd0;
            cnt_d   = 3'd0;
            state_d = (state_q == S_LOAD_A) ? S_LOAD_B : S_RUN;
          end else begin
            idx_d = idx_q + 5'd1;
          end
        end
      end
      S_RUN: begin
        if (cnt_q == 3'd4) begin
          state_d = S_CHECK;
          cnt_d   = 3'd0;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      S_CHECK: begin
        res_d   = mult_result;
        error_d = error_q | ~mult_done;
        idx_d   = 5'd0;
        state_d = S_SEND;
      end
      S_SEND: begin
        if (out_ready) begin
          if (last_idx) begin
            idx_d        = 5'd0;
            frame_done_d = 1'b1;
            state_d      = S_LOAD_A;
          end else begin
            idx_d = idx_q + 5'd1;
          end
        end
      end
      default: state_d = S_SYNC;
    endcase
  end

  always_comb begin
    send_byte = 8'd0;
    for (int k = 0; k < 25; k++) begin
      if (idx_q == 5'(k)) send_byte = res_q[8*k +: 8];
    end
    in_ready   = (state_q == S_LOAD_A) || (state_q == S_LOAD_B);
    out_valid  = (state_q == S_SEND);
    out_data   = (state_q == S_SEND) ? send_byte : 8'd0;
    mult_start = (state_q == S_SYNC) ? ~sync_hit : (state_q == S_RUN);
  end

  assign matrix_a   = mat_a_q;
  assign matrix_b   = mat_b_q;
  assign frame_done = frame_done_q;
  assign error      = error_q;

endmodule

// File: doc/matrix_stream_controller.md
# matrix_stream_controller

Byte-stream front/back end for the 5x5 signed 8-bit matrix multiplier. Accepts 50 bytes (matrix A, then matrix B) over a valid/ready input stream and assembles them into the 200-bit packed operands. It drives the multiplier's `start` for exactly one 5-row pass and checks `done`. It then captures the 200-bit result and returns it as 25 bytes over a valid/ready output stream. It also aligns the multiplier's internal row counter after reset, because the multiplier itself has no reset.

## Interface
Parameters: none (matrix size fixed at 5x5, 8-bit elements).
- clock  in  1  system clock, all logic on posedge
- reset  in  1  synchronous, active-high reset
- in_data  in  8  input byte
- in_valid  in  1  input byte valid
- in_ready  out  1  controller can accept a byte
- out_data  out  8  result byte
- out_valid  out  1  result byte valid
- out_ready  in  1  downstream accepts the byte
- matrix_a  out  200  packed A to multiplier (registered)
- matrix_b  out  200  packed B to multiplier (registered)
- mult_start  out  1  multiplier start
- mult_result  in  200  multiplier result
- mult_done  in  1  multiplier done
- frame_done  out  1  one-cycle pulse after the last result byte is accepted
- error  out  1  sticky: `mult_done` was low at CHECK; cleared only by reset

## Operation
- Packing: element [r][c] has index k = 5r+c. It occupies bits [8k+7:8k] of `matrix_a`, `matrix_b` and `mult_result`. Bytes travel in ascending k order.
- Transfer rule: a byte moves when valid && ready at a posedge. Data may not change while valid is high and ready is low.
- States: SYNC, LOAD_A, LOAD_B, RUN, CHECK, SEND. A 5-bit byte index and a 3-bit cycle counter are shared across states.
- SYNC (entered on reset):
  - `in_ready`=0.
  - `mult_start` = !(cnt != 0 && mult_done). This is the only combinational term on `mult_start`.
  - The cnt guard ignores a stale `done` left over from an earlier pass.
  - When `mult_done`=1 with cnt != 0, the multiplier row is 0. That cycle `mult_start`=0 and the next state is LOAD_A.
  - cnt saturates at 7; SYNC completes within 6 cycles.
- LOAD_A: `in_ready`=1. Each accepted byte writes `matrix_a` element[idx]. After idx 24, idx returns to 0 and the next state is LOAD_B.
- LOAD_B: same as LOAD_A but writes `matrix_b`. After idx 24, the next state is RUN.
- RUN: `mult_start`=1 for exactly 5 cycles (cnt 0..4), then CHECK. `matrix_a` and `matrix_b` are held stable.
- CHECK (1 cycle):
  - `mult_start`=0.
  - Capture `mult_result` into the output buffer.
  - If `mult_done`=0, set `error`. Proceed to SEND either way.
- SEND: `out_valid`=1 and `out_data` = buffer element[idx]. Advance idx on each accepted byte. After idx 24: pulse `frame_done`, return to LOAD_A.
- Arithmetic is performed by the multiplier. Each result element is the low 8 bits of the 16-bit signed dot product (wraps). The controller performs no arithmetic.

## Timing
- Reset values: state=SYNC; `in_ready`=0; `out_valid`=0; `out_data`=0; `matrix_a`=0; `matrix_b`=0; result buffer=0; `frame_done`=0; `error`=0; idx=0; cnt=0. `mult_start` is 1 in the first SYNC cycle.
- Reset mid-operation (any state) abandons the frame. Partial bytes are discarded and SYNC re-aligns the multiplier row.
- The last B byte is accepted at edge E. RUN occupies the cycles after edges E..E+4, CHECK the cycle after E+5, and `out_valid` rises at edge E+6.
- Full-frame throughput with no stalls is 50 + 5 + 1 + 25 = 81 cycles.
- `frame_done` is high for exactly the cycle after the 25th output transfer; `in_ready` is high in that same cycle.
- Input and output are never both active: `in_ready` is 0 in SEND and `out_valid` is 0 outside SEND.
- `out_valid` holds, with constant `out_data`, until `out_ready`.

## Test plan
- Identity: reset, A = identity (0x01 on the diagonal, else 0x00), B bytes k=0..24 -> output bytes 0x00..0x18 in order, `frame_done` pulse, `error`=0.
- Constants: A all 0x02, B all 0x03 -> 25 output bytes of 0x1E.
- Overflow wrap: A and B all 0x7F -> each element 80645 truncates to 0x3B05, so output bytes are all 0x05. Negative: A all 0xFF, B identity -> all 0xFF.
- Backpressure: random `in_valid` gaps and `out_ready` toggling at 50% -> same bytes as the no-stall run, `out_data` stable while stalled, no byte dropped or duplicated, first `out_valid` exactly 6 edges after the last B accept when unstalled.
- Reset mid-RUN (cycle 3), then load A identity and B k -> SYNC completes within 6 cycles, then the output is 0x00..0x18. Also, back-to-back frames with no reset both produce correct results.
- Fault: the bench model holds `mult_done`=0 at CHECK -> `error` rises and stays 1 through the next frame until reset; the output bytes are still sent.
